// File: rtl/mdl_spgen_pkg.sv
// Shared definitions for the bubble write-side sync pattern generator:
// FSM state encodings, default geometry and CRC-16-CCITT constants.
package mdl_spgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_TIP  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4
    } spgen_state_t;

    localparam int          DEF_ZERO_BITS     = 128;
    localparam int          DEF_PAYLOAD_BYTES = 64;
    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [15:0] CRC16_INIT        = 16'hFFFF;

    // One serial CRC-16-CCITT step, data bit taken in transmission order.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/mdl_spgen_if.sv
// Handshake/bus bundle between the DMA byte fetch, the sync pattern
// generator and the bubble write driver.  Clock and reset stay outside.
interface mdl_spgen_if;
    logic       i_CLK2M_PCEN_n;
    logic       i_GLCNT_RD;
    logic       i_BSEN_n;
    logic       i_4BEN_n;
    logic       i_START;
    logic [7:0] i_WDATA;
    logic       i_WDATA_VLD;
    logic       o_WDATA_ACK;
    logic       o_BDO;
    logic       o_SYNCTIP_n;
    logic       o_BUSY;
    logic       o_DONE;
    logic       o_UNDERRUN;

    modport master (
        output i_CLK2M_PCEN_n, i_GLCNT_RD, i_BSEN_n, i_4BEN_n, i_START,
               i_WDATA, i_WDATA_VLD,
        input  o_WDATA_ACK, o_BDO, o_SYNCTIP_n, o_BUSY, o_DONE, o_UNDERRUN
    );

    modport slave (
        input  i_CLK2M_PCEN_n, i_GLCNT_RD, i_BSEN_n, i_4BEN_n, i_START,
               i_WDATA, i_WDATA_VLD,
        output o_WDATA_ACK, o_BDO, o_SYNCTIP_n, o_BUSY, o_DONE, o_UNDERRUN
    );
endinterface

// File: rtl/mdl_spgen_crc16.sv
// Serial CRC-16-CCITT LFSR.  clr reloads the init value; each bit_en
// folds one data bit in.  Only instantiated when SPGEN_CRC16_EN is defined.
module mdl_spgen_crc16
    import mdl_spgen_pkg::*;
(
    input  logic        i_MCLK,
    input  logic        i_SYS_RST_n,
    input  logic        clr,
    input  logic        bit_en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    // LFSR register: clear wins over a data step
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            crc_q <= CRC16_INIT;
        end else if (clr) begin
            crc_q <= CRC16_INIT;
        end else if (bit_en) begin
            crc_q <= crc16_step(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mdl_spgen.sv
// Bubble write-side sync pattern generator and serializer.
// Frame: ZERO_BITS zeros, one sync-tip "1", PAYLOAD_BYTES bytes LSB-first,
// optionally followed by a 16-bit CRC-16-CCITT when SPGEN_CRC16_EN is defined.
// All state advances on 2MHz enables; bits advance only on good-loop slots.
module mdl_spgen
    import mdl_spgen_pkg::*;
#(
    parameter int ZERO_BITS     = DEF_ZERO_BITS,
    parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES
)(
    input  logic        i_MCLK,
    input  logic        i_SYS_RST_n,
    mdl_spgen_if.slave  bus
);

    spgen_state_t state, state_nxt;

    logic       en;
    logic       go, abort, pre_slot, tip_slot, data_slot, fetch, frame_end;
    logic [7:0] zero_cnt;
    logic [7:0] byte_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] tip_dly_n;
    logic       bdo_q, synctip_n_q, done_q, ack_q, underrun_q;

`ifdef SPGEN_CRC16_EN
    logic        crc_slot;
    logic [3:0]  crc_cnt;
    logic [15:0] crc_val;

    mdl_spgen_crc16 u_crc16 (
        .i_MCLK      (i_MCLK),
        .i_SYS_RST_n (i_SYS_RST_n),
        .clr         (go),
        .bit_en      (data_slot),
        .din         (shift_reg[0]),
        .crc         (crc_val)
    );
`endif

    assign en = ~bus.i_CLK2M_PCEN_n;

    // State register
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-enable action decode; abort outranks any slot work
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        abort     = 1'b0;
        pre_slot  = 1'b0;
        tip_slot  = 1'b0;
        data_slot = 1'b0;
        fetch     = 1'b0;
        frame_end = 1'b0;
`ifdef SPGEN_CRC16_EN
        crc_slot  = 1'b0;
`endif
        if (en) begin
            if (state == ST_IDLE) begin
                if (bus.i_START && !bus.i_BSEN_n) begin
                    state_nxt = ST_PRE;
                    go        = 1'b1;
                end
            end else if (bus.i_BSEN_n) begin
                abort     = 1'b1;
                state_nxt = ST_IDLE;
            end else if (bus.i_GLCNT_RD) begin
                case (state)
                    ST_PRE: begin
                        pre_slot = 1'b1;
                        if (zero_cnt == 8'd0) begin
                            state_nxt = ST_TIP;
                        end
                    end
                    ST_TIP: begin
                        tip_slot  = 1'b1;
                        fetch     = 1'b1;
                        state_nxt = ST_DATA;
                    end
                    ST_DATA: begin
                        data_slot = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == 8'd0) begin
`ifdef SPGEN_CRC16_EN
                                state_nxt = ST_CRC;
`else
                                state_nxt = ST_IDLE;
                                frame_end = 1'b1;
`endif
                            end else begin
                                fetch = 1'b1;
                            end
                        end
                    end
`ifdef SPGEN_CRC16_EN
                    ST_CRC: begin
                        crc_slot = 1'b1;
                        if (crc_cnt == 4'd15) begin
                            state_nxt = ST_IDLE;
                            frame_end = 1'b1;
                        end
                    end
`endif
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Counters, shift register, output bit, pulses and sync-tip delay line
    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            zero_cnt    <= 8'd0;
            byte_cnt    <= 8'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            tip_dly_n   <= 8'hFF;
            bdo_q       <= 1'b0;
            synctip_n_q <= 1'b1;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef SPGEN_CRC16_EN
            crc_cnt     <= 4'd0;
`endif
        end else if (en) begin
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            // 2-bit mode reports the tip 8 enables late, matching the detector
            tip_dly_n   <= {tip_dly_n[6:0], ~tip_slot};
            synctip_n_q <= bus.i_4BEN_n ? tip_dly_n[7] : ~tip_slot;
            if (go) begin
                zero_cnt   <= 8'(ZERO_BITS - 1);
                underrun_q <= 1'b0;
                bdo_q      <= 1'b0;
            end else if (abort) begin
                bdo_q       <= 1'b0;
                tip_dly_n   <= 8'hFF;
                synctip_n_q <= 1'b1;
            end else begin
                if (state == ST_IDLE) begin
                    bdo_q <= 1'b0;
                end
                if (pre_slot) begin
                    bdo_q <= 1'b0;
                    if (zero_cnt != 8'd0) begin
                        zero_cnt <= zero_cnt - 8'd1;
                    end
                end
                if (tip_slot) begin
                    bdo_q    <= 1'b1;
                    byte_cnt <= 8'(PAYLOAD_BYTES - 1);
                    bit_cnt  <= 3'd0;
`ifdef SPGEN_CRC16_EN
                    crc_cnt  <= 4'd0;
`endif
                end
                if (data_slot) begin
                    bdo_q     <= shift_reg[0];
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7 && byte_cnt != 8'd0) begin
                        byte_cnt <= byte_cnt - 8'd1;
                    end
                end
                // A fetch replaces the shift so the next slot sends the new bit 0
                if (fetch) begin
                    if (bus.i_WDATA_VLD) begin
                        shift_reg <= bus.i_WDATA;
                        ack_q     <= 1'b1;
                    end else begin
                        shift_reg  <= 8'h00;
                        underrun_q <= 1'b1;
                    end
                end
`ifdef SPGEN_CRC16_EN
                if (crc_slot) begin
                    bdo_q   <= crc_val[4'd15 - crc_cnt];
                    crc_cnt <= crc_cnt + 4'd1;
                end
`endif
                if (frame_end) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_BDO       = bdo_q;
    assign bus.o_SYNCTIP_n = synctip_n_q;
    assign bus.o_BUSY      = (state != ST_IDLE);
    assign bus.o_DONE      = done_q;
    assign bus.o_WDATA_ACK = ack_q;
    assign bus.o_UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_mdl_spgen.sv
// Directed bench for mdl_spgen: full frames in both tip modes, sparse
// good-loop slots, payload underrun, abort in preamble, async reset
// mid-payload and (with SPGEN_CRC16_EN) the trailing CRC.
module tb_mdl_spgen;

    localparam int ZB = 128;
`ifdef SPGEN_CRC16_EN
    localparam int PB = 1;
    localparam int CB = 16;
`else
    localparam int PB = 2;
    localparam int CB = 0;
`endif
    localparam int TOTAL = ZB + 1 + 8 * PB + CB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdl_spgen_if bus ();

    mdl_spgen #(.ZERO_BITS(ZB), .PAYLOAD_BYTES(PB)) u_dut (
        .i_MCLK      (clk),
        .i_SYS_RST_n (rst_n),
        .bus         (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    logic exp_bits [0:1023];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One enable clock followed by one idle clock; outputs sampled afterwards
    task automatic tick(input logic rd);
        bus.i_GLCNT_RD     = rd;
        bus.i_CLK2M_PCEN_n = 1'b0;
        @(posedge clk); #1;
        bus.i_CLK2M_PCEN_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input string nm, input logic mode_n, input bit alt,
                             input int ur_idx, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0]  bytes [2];
        logic [7:0]  b;
        logic [15:0] crc;
        logic        fb, rd;
        int n, s, e, k, acks, tip_e, st_e, st_cnt, done_e, done_exp;
        bytes[0] = d0;
        bytes[1] = d1;
        n = 0;
        for (int i = 0; i < ZB; i++) exp_bits[n++] = 1'b0;
        exp_bits[n++] = 1'b1;
        crc = 16'hFFFF;
        for (int j = 0; j < PB; j++) begin
            b = (j == ur_idx) ? 8'h00 : bytes[j];
            for (int i = 0; i < 8; i++) begin
                exp_bits[n++] = b[i];
                fb  = crc[15] ^ b[i];
                crc = {crc[14:0], 1'b0};
                if (fb) crc = crc ^ 16'h1021;
            end
        end
        if (CB != 0) begin
            for (int i = 15; i >= 0; i--) exp_bits[n++] = crc[i];
        end

        bus.i_4BEN_n = mode_n;
        bus.i_BSEN_n = 1'b0;
        bus.i_START  = 1'b1;
        tick(1'b1);
        bus.i_START  = 1'b0;
        check_eq({nm, "_busy_start"}, 32'(bus.o_BUSY), 1);
        check_eq({nm, "_ur_clear"}, 32'(bus.o_UNDERRUN), 0);

        s = 0; e = 0; acks = 0; tip_e = -1; st_e = -1; st_cnt = 0; done_e = -1; done_exp = -2;
        while (s < TOTAL && e < 4 * TOTAL) begin
            rd = alt ? e[0] : 1'b1;
            bus.i_WDATA     = 8'hFF;
            bus.i_WDATA_VLD = 1'b0;
            if (rd && s >= ZB && ((s - ZB) % 8) == 0 && ((s - ZB) / 8) < PB) begin
                k = (s - ZB) / 8;
                bus.i_WDATA     = bytes[k];
                bus.i_WDATA_VLD = (k != ur_idx);
            end
            tick(rd);
            if (rd) begin
                if (s == ZB) tip_e = e;
                s++;
                if (s == TOTAL) done_exp = e;
            end
            check_eq($sformatf("%s_bdo_e%0d", nm, e), 32'(bus.o_BDO),
                     (s > 0) ? 32'(exp_bits[s-1]) : 0);
            if (bus.o_WDATA_ACK) acks++;
            if (!bus.o_SYNCTIP_n) begin
                st_cnt++;
                if (st_e < 0) st_e = e;
            end
            if (bus.o_DONE) done_e = e;
            e++;
        end
        check_eq({nm, "_slots"}, s, TOTAL);
        check_eq({nm, "_busy_end"}, 32'(bus.o_BUSY), 0);
        check_eq({nm, "_done_pos"}, done_e, done_exp);
        check_eq({nm, "_tip_pos"}, st_e, mode_n ? tip_e + 8 : tip_e);
        check_eq({nm, "_tip_cnt"}, st_cnt, 1);
        check_eq({nm, "_acks"}, acks, (ur_idx >= 0) ? PB - 1 : PB);
        tick(1'b1);
        check_eq({nm, "_bdo_idle"}, 32'(bus.o_BDO), 0);
        check_eq({nm, "_done_width"}, 32'(bus.o_DONE), 0);
        check_eq({nm, "_ur_sticky"}, 32'(bus.o_UNDERRUN), (ur_idx >= 0) ? 1 : 0);
    endtask

    initial begin
        int dones;
        bus.i_CLK2M_PCEN_n = 1'b1;
        bus.i_GLCNT_RD     = 1'b0;
        bus.i_BSEN_n       = 1'b0;
        bus.i_4BEN_n       = 1'b0;
        bus.i_START        = 1'b0;
        bus.i_WDATA        = 8'h00;
        bus.i_WDATA_VLD    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bdo",     32'(bus.o_BDO),       0);
        check_eq("rst_synctip", 32'(bus.o_SYNCTIP_n), 1);
        check_eq("rst_busy",    32'(bus.o_BUSY),      0);
        check_eq("rst_done",    32'(bus.o_DONE),      0);
        check_eq("rst_ack",     32'(bus.o_WDATA_ACK), 0);
        check_eq("rst_ur",      32'(bus.o_UNDERRUN),  0);
        rst_n = 1'b1;
        tick(1'b1);

        run_frame("basic4", 1'b0, 1'b0, -1, 8'hA5, 8'h3C);
        run_frame("sparse", 1'b0, 1'b1, -1, 8'hA5, 8'h3C);
        run_frame("mode2",  1'b1, 1'b0, -1, 8'hA5, 8'h3C);
        run_frame("under",  1'b0, 1'b0, PB - 1, 8'hA5, 8'h3C);
        run_frame("zeroff", 1'b0, 1'b0, -1, 8'h00, 8'hFF);

        // Abort on preamble slot 50
        bus.i_4BEN_n = 1'b1;
        bus.i_START  = 1'b1;
        tick(1'b1);
        bus.i_START  = 1'b0;
        for (int i = 0; i < 49; i++) tick(1'b1);
        check_eq("abort_busy_before", 32'(bus.o_BUSY), 1);
        bus.i_BSEN_n = 1'b1;
        tick(1'b1);
        check_eq("abort_busy", 32'(bus.o_BUSY), 0);
        check_eq("abort_bdo",  32'(bus.o_BDO),  0);
        check_eq("abort_done", 32'(bus.o_DONE), 0);
        bus.i_BSEN_n = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (bus.o_DONE || !bus.o_SYNCTIP_n) dones++;
        end
        check_eq("abort_quiet", dones, 0);
        check_eq("abort_idle",  32'(bus.o_BUSY), 0);

        // Async reset in the middle of the payload
        bus.i_4BEN_n    = 1'b0;
        bus.i_WDATA     = 8'hFF;
        bus.i_WDATA_VLD = 1'b1;
        bus.i_START     = 1'b1;
        tick(1'b1);
        bus.i_START     = 1'b0;
        for (int i = 0; i < ZB + 1; i++) tick(1'b1);
        check_eq("mid_tip",  32'(bus.o_SYNCTIP_n), 0);
        check_eq("mid_ack",  32'(bus.o_WDATA_ACK), 1);
        tick(1'b1);
        tick(1'b1);
        check_eq("mid_bdo",  32'(bus.o_BDO),  1);
        check_eq("mid_busy", 32'(bus.o_BUSY), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_bdo",     32'(bus.o_BDO),       0);
        check_eq("arst_busy",    32'(bus.o_BUSY),      0);
        check_eq("arst_synctip", 32'(bus.o_SYNCTIP_n), 1);
        check_eq("arst_ack",     32'(bus.o_WDATA_ACK), 0);
        check_eq("arst_done",    32'(bus.o_DONE),      0);
        check_eq("arst_ur",      32'(bus.o_UNDERRUN),  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b1);
        check_eq("post_rst_idle", 32'(bus.o_BUSY), 0);
        check_eq("post_rst_bdo",  32'(bus.o_BDO),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
